// File: rtl/uart_rx_frame_parser_if.sv
// Byte-in / frame-out signal bundle for uart_rx_frame_parser.
// The parser connects through "master"; the UART driver and frame consumer side connects through "slave".
interface uart_rx_frame_parser_if #(
    parameter int P_DATA_WIDTH = 8
);
    logic [P_DATA_WIDTH-1:0] i_rx_data;
    logic                    i_rx_valid;
    logic [P_DATA_WIDTH-1:0] o_frame_data;
    logic                    o_frame_valid;
    logic                    i_frame_ready;
    logic                    o_frame_last;
    logic [7:0]              o_frame_len;
    logic                    o_err;
    logic [2:0]              o_err_code;
    logic                    o_busy;

    modport master (
        input  i_rx_data, i_rx_valid, i_frame_ready,
        output o_frame_data, o_frame_valid, o_frame_last, o_frame_len,
        output o_err, o_err_code, o_busy
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_frame_ready,
        input  o_frame_data, o_frame_valid, o_frame_last, o_frame_len,
        input  o_err, o_err_code, o_busy
    );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Hunts for 55 AA LEN payload CHK frames in the received byte stream, buffers the payload
// until the XOR checksum is verified, then replays it over a valid/ready stream.
module uart_rx_frame_parser #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_MAX_LEN    = 16,
    parameter int P_TIMEOUT    = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    uart_rx_frame_parser_if.master bus
);
    localparam int IW = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam logic [P_DATA_WIDTH-1:0] SYNC0 = P_DATA_WIDTH'(8'h55);
    localparam logic [P_DATA_WIDTH-1:0] SYNC1 = P_DATA_WIDTH'(8'hAA);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t                  state_reg;
    logic                    rx_valid_d_reg;
    logic [P_DATA_WIDTH-1:0] mem_reg [P_MAX_LEN];
    logic [IW-1:0]           idx_reg;
    logic [IW-1:0]           rd_reg;
    logic [TW-1:0]           tmo_reg;
    logic [P_DATA_WIDTH-1:0] chk_reg;
    logic [P_DATA_WIDTH-1:0] data_reg;
    logic [7:0]              len_reg;
    logic                    valid_reg;
    logic                    last_reg;
    logic                    err_reg;
    logic [2:0]              err_code_reg;
    logic                    busy_reg;

    logic          ev;
    logic          handshake;
    logic          in_frame;
    logic          timed_out;
    logic [IW-1:0] rd_last;
    logic [IW-1:0] rd_inc;

    assign ev        = bus.i_rx_valid & ~rx_valid_d_reg;
    assign handshake = valid_reg & bus.i_frame_ready;
    assign in_frame  = (state_reg == S_HDR1) || (state_reg == S_LEN) ||
                       (state_reg == S_PAYLOAD) || (state_reg == S_CHK);
    // A byte arriving in the same cycle the budget runs out takes priority.
    assign timed_out = in_frame && !ev && (tmo_reg == TW'(P_TIMEOUT - 1));
    assign rd_last   = IW'(len_reg - 8'd1);
    assign rd_inc    = rd_reg + 1'b1;

    // Payload buffer: written only while collecting, so it is stable during the drain.
    always_ff @(posedge i_clk) begin
        if (ev && state_reg == S_PAYLOAD) begin
            mem_reg[idx_reg] <= bus.i_rx_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= S_IDLE;
            rx_valid_d_reg <= 1'b0;
            idx_reg        <= '0;
            rd_reg         <= '0;
            tmo_reg        <= '0;
            chk_reg        <= '0;
            data_reg       <= '0;
            len_reg        <= '0;
            valid_reg      <= 1'b0;
            last_reg       <= 1'b0;
            err_reg        <= 1'b0;
            err_code_reg   <= '0;
            busy_reg       <= 1'b0;
        end else begin
            rx_valid_d_reg <= bus.i_rx_valid;
            err_reg        <= 1'b0;

            if (ev || !in_frame) begin
                tmo_reg <= '0;
            end else begin
                tmo_reg <= tmo_reg + 1'b1;
            end

            if (timed_out) begin
                state_reg    <= S_IDLE;
                busy_reg     <= 1'b0;
                err_reg      <= 1'b1;
                err_code_reg <= 3'd3;
                tmo_reg      <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (ev && bus.i_rx_data == SYNC0) begin
                            state_reg <= S_HDR1;
                            busy_reg  <= 1'b1;
                        end
                    end
                    S_HDR1: begin
                        if (ev) begin
                            if (bus.i_rx_data == SYNC1) begin
                                state_reg <= S_LEN;
                            end else if (bus.i_rx_data != SYNC0) begin
                                state_reg <= S_IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end
                    end
                    S_LEN: begin
                        if (ev) begin
                            if (bus.i_rx_data == '0 ||
                                bus.i_rx_data > P_DATA_WIDTH'(P_MAX_LEN)) begin
                                state_reg    <= S_IDLE;
                                busy_reg     <= 1'b0;
                                err_reg      <= 1'b1;
                                err_code_reg <= 3'd1;
                            end else begin
                                len_reg   <= 8'(bus.i_rx_data);
                                chk_reg   <= bus.i_rx_data;
                                idx_reg   <= '0;
                                state_reg <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (ev) begin
                            chk_reg <= chk_reg ^ bus.i_rx_data;
                            if (8'(idx_reg) == len_reg - 8'd1) begin
                                state_reg <= S_CHK;
                            end else begin
                                idx_reg <= idx_reg + 1'b1;
                            end
                        end
                    end
                    S_CHK: begin
                        if (ev) begin
                            if (bus.i_rx_data == chk_reg) begin
                                state_reg <= S_DRAIN;
                                rd_reg    <= '0;
                                data_reg  <= mem_reg[IW'(0)];
                                last_reg  <= (len_reg == 8'd1);
                                valid_reg <= 1'b1;
                            end else begin
                                state_reg    <= S_IDLE;
                                busy_reg     <= 1'b0;
                                err_reg      <= 1'b1;
                                err_code_reg <= 3'd2;
                            end
                        end
                    end
                    S_DRAIN: begin
                        // Bytes arriving now are dropped; the buffered frame keeps draining.
                        if (ev) begin
                            err_reg      <= 1'b1;
                            err_code_reg <= 3'd4;
                        end
                        if (handshake) begin
                            if (rd_reg == rd_last) begin
                                valid_reg <= 1'b0;
                                last_reg  <= 1'b0;
                                state_reg <= S_IDLE;
                                busy_reg  <= 1'b0;
                            end else begin
                                rd_reg   <= rd_inc;
                                data_reg <= mem_reg[rd_inc];
                                last_reg <= (rd_inc == rd_last);
                            end
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_frame_data  = data_reg;
    assign bus.o_frame_valid = valid_reg;
    assign bus.o_frame_last  = last_reg;
    assign bus.o_frame_len   = len_reg;
    assign bus.o_err         = err_reg;
    assign bus.o_err_code    = err_code_reg;
    assign bus.o_busy        = busy_reg;
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser: stimulus queues expected beats and error codes,
// a negedge monitor pops and compares them whenever the DUT hands over a byte or pulses o_err.
module tb_uart_rx_frame_parser;
    localparam int DW     = 8;
    localparam int MAXLEN = 16;
    localparam int TMO    = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_frame_parser_if #(.P_DATA_WIDTH(DW)) bus ();

    uart_rx_frame_parser #(
        .P_DATA_WIDTH(DW),
        .P_MAX_LEN   (MAXLEN),
        .P_TIMEOUT   (TMO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] len;
    } beat_t;

    beat_t exp_beats[$];
    int    exp_errs[$];
    int    hs_cycles[$];
    int    checks = 0;
    int    errors = 0;
    int    cycle  = 0;
    logic  toggle_en = 1'b0;

    beat_t      mon_beat;
    int         mon_code;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [7:0] prev_len;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.o_frame_valid) begin
                check("stall_data", bus.o_frame_data, prev_data);
                check("stall_last", bus.o_frame_last, prev_last);
                check("stall_len",  bus.o_frame_len,  prev_len);
            end
            if (bus.o_frame_valid && bus.i_frame_ready) begin
                hs_cycles.push_back(cycle);
                if (exp_beats.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%02h, expected no beat", bus.o_frame_data);
                end else begin
                    mon_beat = exp_beats.pop_front();
                    check("beat_data", bus.o_frame_data, mon_beat.data);
                    check("beat_last", bus.o_frame_last, mon_beat.last);
                    check("beat_len",  bus.o_frame_len,  mon_beat.len);
                    $display("beat data=0x%02h last=%0b len=%0d", bus.o_frame_data, bus.o_frame_last, bus.o_frame_len);
                end
            end
            if (bus.o_err) begin
                if (exp_errs.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_err: got code %0d, expected no error", bus.o_err_code);
                end else begin
                    mon_code = exp_errs.pop_front();
                    check("err_code", bus.o_err_code, mon_code);
                    $display("err code=%0d", bus.o_err_code);
                end
            end
            prev_stall = bus.o_frame_valid && !bus.i_frame_ready;
            prev_data  = bus.o_frame_data;
            prev_last  = bus.o_frame_last;
            prev_len   = bus.o_frame_len;
        end
    end

    always @(posedge clk) begin
        if (toggle_en) begin
            #1;
            bus.i_frame_ready = ~bus.i_frame_ready;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk);
        #1;
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input int hold);
        foreach (bytes[k]) send_byte(bytes[k], hold);
    endtask

    task automatic expect_payload(input logic [7:0] bytes[$]);
        beat_t b;
        foreach (bytes[k]) begin
            b.data = bytes[k];
            b.last = (k == bytes.size() - 1);
            b.len  = 8'(bytes.size());
            exp_beats.push_back(b);
        end
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while ((exp_beats.size() != 0 || exp_errs.size() != 0 ||
                bus.o_busy || bus.o_frame_valid) && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({name, "_settled"}, int'(n < 500), 1);
        check({name, "_busy"}, bus.o_busy, 0);
    endtask

    initial begin
        bus.i_rx_data     = '0;
        bus.i_rx_valid    = 1'b0;
        bus.i_frame_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_data",  bus.o_frame_data,  0);
        check("rst_valid", bus.o_frame_valid, 0);
        check("rst_last",  bus.o_frame_last,  0);
        check("rst_len",   bus.o_frame_len,   0);
        check("rst_err",   bus.o_err,         0);
        check("rst_code",  bus.o_err_code,    0);
        check("rst_busy",  bus.o_busy,        0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Good frame, ready high: three consecutive beats
        hs_cycles.delete();
        expect_payload('{8'h11, 8'h22, 8'h33});
        send_frame('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}, 1);
        wait_drained("good");
        check("good_beats", hs_cycles.size(), 3);
        if (hs_cycles.size() == 3) check("good_consecutive", hs_cycles[2] - hs_cycles[0], 2);

        // Checksum error
        exp_errs.push_back(2);
        send_frame('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04}, 1);
        wait_drained("badchk");

        // Backpressure: ready toggles every cycle; chk = 04^A1^B2^C3^D4 = 00
        toggle_en = 1'b1;
        expect_payload('{8'hA1, 8'hB2, 8'hC3, 8'hD4});
        send_frame('{8'h55, 8'hAA, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00}, 1);
        wait_drained("bp");
        toggle_en = 1'b0;
        @(posedge clk);
        #1;
        bus.i_frame_ready = 1'b1;

        // Length errors, trailing bytes ignored
        exp_errs.push_back(1);
        send_frame('{8'h55, 8'hAA, 8'h00}, 1);
        wait_drained("len0");
        exp_errs.push_back(1);
        send_frame('{8'h55, 8'hAA, 8'h11, 8'h22, 8'h33, 8'hAA, 8'h01}, 1);
        wait_drained("len17");

        // Resync on repeated 0x55, stretched valid; chk = 01^7E = 7F
        expect_payload('{8'h7E});
        send_frame('{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F}, 3);
        wait_drained("resync");

        // Timeout inside payload
        send_frame('{8'h55, 8'hAA, 8'h02, 8'h41}, 1);
        @(negedge clk);
        check("tmo_busy_before", bus.o_busy, 1);
        exp_errs.push_back(3);
        wait_drained("timeout");

        // Overrun during a stalled drain; chk = 02^5A^A5 = FD
        @(posedge clk);
        #1;
        bus.i_frame_ready = 1'b0;
        expect_payload('{8'h5A, 8'hA5});
        send_frame('{8'h55, 8'hAA, 8'h02, 8'h5A, 8'hA5, 8'hFD}, 1);
        repeat (3) @(posedge clk);
        exp_errs.push_back(4);
        send_byte(8'h55, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("ovr_valid_held", bus.o_frame_valid, 1);
        check("ovr_data_held",  bus.o_frame_data,  8'h5A);
        @(posedge clk);
        #1;
        bus.i_frame_ready = 1'b1;
        wait_drained("overrun");

        // Reset mid-frame discards the partial frame
        send_frame('{8'h55, 8'hAA, 8'h02, 8'h10}, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("midrst_valid", bus.o_frame_valid, 0);
        wait_drained("midrst");

        check("beats_left", exp_beats.size(), 0);
        check("errs_left",  exp_errs.size(),  0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
